// File: rtl/pulse_gen.sv
// Periodic pulse / PWM generator with a double-buffered config port.
// Optional one-shot mode: define PULSE_GEN_ONESHOT_EN.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   en           run enable
//   oneshot      (PULSE_GEN_ONESHOT_EN only) stop after one period
//   cfg_valid    new config offered
//   cfg_ready    config slot free (no config pending)
//   cfg_period   period-1 (N gives N+1 cycles)
//   cfg_high     cycles out is high per period
//   out          pulse/PWM output
//   cnt_val      current phase count
//   wrap         high on the last cycle of a period
module pulse_gen #(
    parameter int WIDTH        = 8,
    parameter int RESET_PERIOD = 4,
    parameter int RESET_HIGH   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
`ifdef PULSE_GEN_ONESHOT_EN
    input  logic             oneshot,
`endif
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             out,
    output logic [WIDTH-1:0] cnt_val,
    output logic             wrap
);

`ifdef PULSE_GEN_ONESHOT_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] high_r;
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_high;
    logic             pending;
    logic             running;
    logic             at_wrap;

    assign running = (state == RUN);
    assign at_wrap = running && (cnt == period_r);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a running period always completes before stopping
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (en) next_state = RUN;
            end
            RUN: begin
                if (at_wrap) begin
                    if (!en) next_state = IDLE;
`ifdef PULSE_GEN_ONESHOT_EN
                    if (oneshot) next_state = DONE;
`endif
                end
            end
`ifdef PULSE_GEN_ONESHOT_EN
            DONE: begin
                if (!en) next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Outputs decode registered state only
    always_comb begin
        out       = running && (cnt < high_r);
        wrap      = at_wrap;
        cfg_ready = !pending;
        cnt_val   = cnt;
    end

    // Phase counter: held at 0 outside RUN, returns to 0 at wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (running && !at_wrap) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Config double buffer. Accept and apply are mutually exclusive
    // (accept needs pending=0, apply needs pending=1), so a transfer
    // landing on a wrap edge waits for the following wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_r      <= WIDTH'(RESET_PERIOD);
            high_r        <= WIDTH'(RESET_HIGH);
            shadow_period <= '0;
            shadow_high   <= '0;
            pending       <= 1'b0;
        end else if (cfg_valid && !pending) begin
            shadow_period <= cfg_period;
            shadow_high   <= cfg_high;
            pending       <= 1'b1;
        end else if (pending && (at_wrap || !running)) begin
            period_r <= shadow_period;
            high_r   <= shadow_high;
            pending  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_pulse_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
`ifdef PULSE_GEN_ONESHOT_EN
    logic       oneshot;
`endif
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic       out;
    logic [7:0] cnt_val;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_gen #(
        .WIDTH(8),
        .RESET_PERIOD(4),
        .RESET_HIGH(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
`ifdef PULSE_GEN_ONESHOT_EN
        .oneshot(oneshot),
`endif
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_period(cfg_period),
        .cfg_high(cfg_high),
        .out(out),
        .cnt_val(cnt_val),
        .wrap(wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input string tag, input int c, input bit o,
                       input bit w, input bit r);
        chk({tag, ".cnt"}, 32'(cnt_val), 32'(c));
        chk({tag, ".out"}, 32'(out), 32'(o));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(r));
    endtask

    task automatic send(input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_period = 8'(p);
        cfg_high   = 8'(h);
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b0;
`ifdef PULSE_GEN_ONESHOT_EN
        oneshot    = 1'b0;
`endif
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        tick();
        tick();
        cyc("reset", 0, 0, 0, 1);
        reset = 1'b0;
        tick();
        cyc("idle", 0, 0, 0, 1);

        // Default period 5, high 1; out rises one cycle after en
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            cyc("dflt", i % 5, (i % 5) == 0, (i % 5) == 4, 1);
        end

        // Mid-period config period=9 high=3
        tick();
        cyc("t2.c0", 0, 1, 0, 1);
        tick();
        cyc("t2.c1", 1, 0, 0, 1);
        send(9, 3);
        for (int i = 2; i < 5; i++) begin
            tick();
            cfg_valid = 1'b0;
            cyc("t2.old", i, 0, i == 4, 0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            cyc("t2.new", i, i < 3, i == 9, 1);
        end

        // Transfer on the wrap cycle waits a full period
        send(4, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            cfg_valid = 1'b0;
            cyc("t3.hold", i, i < 3, i == 9, 0);
        end
        // high=0: out never rises; queue high=20 period=9
        for (int i = 0; i < 5; i++) begin
            tick();
            cfg_valid = 1'b0;
            cyc("t3.h0", i, 0, i == 4, i == 0);
            if (i == 0) send(9, 20);
        end
        // high > period: 100%; queue period=0 high=1
        for (int i = 0; i < 10; i++) begin
            tick();
            cfg_valid = 1'b0;
            cyc("t3.full", i, 1, i == 9, i == 0);
            if (i == 0) send(0, 1);
        end
        // period=0: wrap every cycle
        for (int i = 0; i < 3; i++) begin
            tick();
            cyc("t3.p0", 0, 1, 1, 1);
        end
        send(4, 1);
        tick();
        cfg_valid = 1'b0;
        cyc("t3.p0acc", 0, 1, 1, 0);
        tick();
        cyc("t4.c0", 0, 1, 0, 1);

        // Clean stop: en dropped at cnt=1
        tick();
        cyc("t4.c1", 1, 0, 0, 1);
        en = 1'b0;
        tick();
        cyc("t4.c2", 2, 0, 0, 1);
        tick();
        cyc("t4.c3", 3, 0, 0, 1);
        tick();
        cyc("t4.c4", 4, 0, 1, 1);
        tick();
        cyc("t4.idle", 0, 0, 0, 1);
        tick();
        cyc("t4.idle2", 0, 0, 0, 1);

        // Config in IDLE applies on the next edge
        send(2, 2);
        tick();
        cfg_valid = 1'b0;
        cyc("t4.ipend", 0, 0, 0, 0);
        tick();
        cyc("t4.iapply", 0, 0, 0, 1);
        en = 1'b1;
        tick();
        cyc("t4.p2c0", 0, 1, 0, 1);
        tick();
        cyc("t4.p2c1", 1, 1, 0, 1);
        tick();
        cyc("t4.p2c2", 2, 0, 1, 1);
        tick();
        tick();
        cyc("t4.p2c1b", 1, 1, 0, 1);
        send(7, 5);
        tick();
        cfg_valid = 1'b0;
        cyc("t4.pend", 2, 0, 1, 0);

        // Reset mid-run restores defaults and drops the pending config
        reset = 1'b1;
        tick();
        cyc("t4.rst", 0, 0, 0, 1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cyc("t4.dflt", i, i == 0, i == 4, 1);
        end

        // Valid held through wrap with a second config
        tick();
        tick();
        tick();
        cyc("t5.c2", 2, 0, 0, 1);
        send(6, 2);
        tick();
        send(3, 3);
        cyc("t5.c3", 3, 0, 0, 0);
        tick();
        cyc("t5.c4", 4, 0, 1, 0);
        tick();
        cyc("t5.a0", 0, 1, 0, 1);
        for (int i = 1; i < 7; i++) begin
            tick();
            cfg_valid = 1'b0;
            cyc("t5.a", i, i < 2, i == 6, 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc("t5.b", i, i < 3, i == 3, 1);
        end

`ifdef PULSE_GEN_ONESHOT_EN
        // One-shot: one period, then DONE until en re-armed
        en = 1'b0;
        tick();
        cyc("t6.idle", 0, 0, 0, 1);
        oneshot = 1'b1;
        en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc("t6.run", i, i < 3, i == 3, 1);
        end
        tick();
        cyc("t6.done", 0, 0, 0, 1);
        tick();
        cyc("t6.done2", 0, 0, 0, 1);
        en = 1'b0;
        tick();
        cyc("t6.idle2", 0, 0, 0, 1);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc("t6.rerun", i, i < 3, i == 3, 1);
        end
        tick();
        cyc("t6.done3", 0, 0, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
